// File: rtl/cabac_coe_fetch.sv
// Coefficient-group fetch sequencer: walks the 4x4 CGs of one TU in Z-order and streams them to the residual coder.
// Optional feature macro: COE_FETCH_NZ_EN enables per-CG nonzero detection and the tu_cbf/last_cg accumulators.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module cabac_coe_fetch #(
  parameter int CW = `COEFF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [3:0]         tu_x_i,
  input  logic [3:0]         tu_y_i,
  input  logic [1:0]         tu_size_i,
  input  logic [1:0]         tu_sel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               coe_rd_ena_o,
  output logic [8:0]         coe_rd_addr_o,
  output logic [1:0]         coe_rd_sel_o,
  input  logic [16*CW-1:0]   coe_rd_dat_i,
  output logic               cg_valid_o,
  input  logic               cg_ready_i,
  output logic [16*CW-1:0]   cg_dat_o,
  output logic [5:0]         cg_idx_o,
  output logic               cg_nz_o,
  output logic               tu_cbf_o,
  output logic [5:0]         last_cg_o
);

  localparam int DW = 16 * CW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [5:0]    idx;
    logic          nz;
  } ent_t;

  state_e     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [1:0] sel_q, sel_d;
  logic [5:0] nlast_q, nlast_d;
  logic [5:0] cnt_q, cnt_d;
  logic       infl_q, infl_d;
  logic [5:0] infl_idx_q, infl_idx_d;
  logic [1:0] occ_q, occ_d;
  ent_t       head_q, head_d;
  ent_t       tail_q, tail_d;
  logic       cbf_q, cbf_d;
  logic [5:0] last_q, last_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  ent_t       push_ent;
  logic       pop;
  logic       push;
  logic       ena;
  logic [2:0] credit;

  function automatic logic [7:0] morton(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      m[2*k]   = x[k];
      m[2*k+1] = y[k];
    end
    return m;
  endfunction

  // Index of the last CG in a TU; doubles as the mask of low Morton bits a TU spans.
  function automatic logic [5:0] last_of(input logic [1:0] sz);
    logic [5:0] n;
    case (sz)
      2'd0:    n = 6'd0;
      2'd1:    n = 6'd3;
      2'd2:    n = 6'd15;
      default: n = 6'd63;
    endcase
    return n;
  endfunction

  always_comb begin
    pop    = (occ_q != 2'd0) & cg_ready_i;
    push   = infl_q;
    credit = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    // Requests only go out when the slot for their returning data is guaranteed.
    ena    = (state_q == RUN) && (credit < 3'd2);

    push_ent.dat = coe_rd_dat_i;
    push_ent.idx = infl_idx_q;
`ifdef COE_FETCH_NZ_EN
    push_ent.nz  = |coe_rd_dat_i;
`else
    push_ent.nz  = 1'b1;
`endif

    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = push_ent;
        else               tail_d = push_ent;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd2) head_d = tail_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_ent;
        end else begin
          head_d = push_ent;
        end
      end
      default: ;
    endcase

    infl_d     = ena;
    infl_idx_d = ena ? cnt_q : infl_idx_q;

    cbf_d  = cbf_q;
    last_d = last_q;
    if (pop && head_q.nz) begin
      cbf_d  = 1'b1;
      last_d = head_q.idx;
    end

    state_d = state_q;
    base_d  = base_q;
    sel_d   = sel_q;
    nlast_d = nlast_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          nlast_d = last_of(tu_size_i);
          base_d  = morton(tu_x_i, tu_y_i) & ~{2'b00, last_of(tu_size_i)};
          sel_d   = tu_sel_i;
          cnt_d   = 6'd0;
          cbf_d   = 1'b0;
          last_d  = 6'd0;
        end
      end
      RUN: begin
        if (ena) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == nlast_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Look at next-cycle occupancy so done lands right after the final handshake.
        if ((occ_d == 2'd0) && !infl_d) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      sel_q      <= '0;
      nlast_q    <= '0;
      cnt_q      <= '0;
      infl_q     <= 1'b0;
      infl_idx_q <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cbf_q      <= 1'b0;
      last_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      sel_q      <= sel_d;
      nlast_q    <= nlast_d;
      cnt_q      <= cnt_d;
      infl_q     <= infl_d;
      infl_idx_q <= infl_idx_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cbf_q      <= cbf_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign coe_rd_ena_o  = ena;
  assign coe_rd_addr_o = {1'b0, base_q | {2'b00, cnt_q}};
  assign coe_rd_sel_o  = sel_q;
  assign cg_valid_o    = (occ_q != 2'd0);
  assign cg_dat_o      = head_q.dat;
  assign cg_idx_o      = head_q.idx;
  assign cg_nz_o       = head_q.nz;
  assign tu_cbf_o      = cbf_q;
  assign last_cg_o     = last_q;

endmodule

// File: tb/tb_cabac_coe_fetch.sv
// Directed bench for cabac_coe_fetch: TU walks with hand-computed addresses, timing, backpressure and reset.
module tb_cabac_coe_fetch;

  localparam int CW = 16;
  localparam int DW = 16 * CW;
`ifdef COE_FETCH_NZ_EN
  localparam bit NZ = 1'b1;
`else
  localparam bit NZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [3:0]    tu_x_i;
  logic [3:0]    tu_y_i;
  logic [1:0]    tu_size_i;
  logic [1:0]    tu_sel_i;
  logic          busy_o;
  logic          done_o;
  logic          coe_rd_ena_o;
  logic [8:0]    coe_rd_addr_o;
  logic [1:0]    coe_rd_sel_o;
  logic [DW-1:0] coe_rd_dat_i = '1;
  logic          cg_valid_o;
  logic          cg_ready_i = 1'b0;
  logic [DW-1:0] cg_dat_o;
  logic [5:0]    cg_idx_o;
  logic          cg_nz_o;
  logic          tu_cbf_o;
  logic [5:0]    last_cg_o;

  always #5 clk = ~clk;

  cabac_coe_fetch #(.CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .tu_x_i        (tu_x_i),
    .tu_y_i        (tu_y_i),
    .tu_size_i     (tu_size_i),
    .tu_sel_i      (tu_sel_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .coe_rd_ena_o  (coe_rd_ena_o),
    .coe_rd_addr_o (coe_rd_addr_o),
    .coe_rd_sel_o  (coe_rd_sel_o),
    .coe_rd_dat_i  (coe_rd_dat_i),
    .cg_valid_o    (cg_valid_o),
    .cg_ready_i    (cg_ready_i),
    .cg_dat_o      (cg_dat_o),
    .cg_idx_o      (cg_idx_o),
    .cg_nz_o       (cg_nz_o),
    .tu_cbf_o      (tu_cbf_o),
    .last_cg_o     (last_cg_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Current TU expectations, written by the stimulus only.
  logic [8:0]  cur_base;
  logic [1:0]  cur_sel;
  logic [5:0]  cur_nlast;
  logic [63:0] cur_zm;
  logic        exp_cbf;
  logic [5:0]  exp_last;
  bit          mon_en = 1'b0;
  int          rdy_mode = 0;

  // Coefficient source: one nonzero lane per CG, lane chosen by CG index, zero when masked out.
  function automatic logic [DW-1:0] cg_word(input logic [8:0] addr, input logic [5:0] idx,
                                            input logic [63:0] zm);
    logic [DW-1:0] w;
    w = '0;
    if (zm[idx]) w[int'(idx[3:0])*CW +: CW] = CW'(16'h100 | {7'd0, addr});
    return w;
  endfunction

  always @(posedge clk) begin
    if (coe_rd_ena_o) coe_rd_dat_i <= cg_word(coe_rd_addr_o, coe_rd_addr_o[5:0] & cur_nlast, cur_zm);
    else              coe_rd_dat_i <= '1;
  end

  // Monitor state, owned by the negedge process.
  int            t0 = 0;
  int            rel;
  int            reqs, pops, first_req, first_val, done_rel;
  bit            done_seen = 1'b0;
  bit            hold_prev;
  logic [DW-1:0] prev_dat;
  logic [5:0]    prev_idx;
  logic [DW-1:0] w_exp;
  logic          nz_exp;

  bit tog = 1'b0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1: begin
        tog = ~tog;
        cg_ready_i = tog;
      end
      2: cg_ready_i = (first_val >= 0) && ((cyc - t0) >= first_val + 10);
      default: cg_ready_i = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && start_i && !busy_o) begin
      t0 = cyc; reqs = 0; pops = 0;
      first_req = -1; first_val = -1; done_rel = -1;
      done_seen = 1'b0; hold_prev = 1'b0;
    end
    if (rst_n && mon_en) begin
      rel = cyc - t0;
      if (coe_rd_ena_o) begin
        if (first_req < 0) first_req = rel;
        check_val("req_addr", 64'(coe_rd_addr_o), 64'(cur_base | 9'(reqs)));
        check_val("req_sel", 64'(coe_rd_sel_o), 64'(cur_sel));
        reqs++;
      end
      if (cg_valid_o) begin
        if (first_val < 0) first_val = rel;
        if (hold_prev) begin
          check_val("hold_dat", 64'(cg_dat_o == prev_dat), 64'd1);
          check_val("hold_idx", 64'(cg_idx_o), 64'(prev_idx));
        end
        if (cg_ready_i) begin
          w_exp = cg_word(cur_base | 9'(pops), 6'(pops), cur_zm);
          nz_exp = NZ ? cur_zm[pops] : 1'b1;
          check_val("cg_idx", 64'(cg_idx_o), 64'(pops));
          check_val("cg_nz", 64'(cg_nz_o), 64'(nz_exp));
          check_val("cg_dat", 64'(cg_dat_o == w_exp), 64'd1);
          pops++;
        end
      end
      if (coe_rd_ena_o) check_val("credit", 64'((reqs - pops) <= 2), 64'd1);
      hold_prev = cg_valid_o && !cg_ready_i;
      prev_dat  = cg_dat_o;
      prev_idx  = cg_idx_o;
      if (rdy_mode == 2 && rel == 12) check_val("bp_reqs", 64'(reqs), 64'd2);
      if (done_o) begin
        done_rel = rel;
        check_val("tu_cbf", 64'(tu_cbf_o), 64'(exp_cbf));
        check_val("last_cg", 64'(last_cg_o), 64'(exp_last));
        check_val("n_pops", 64'(pops), 64'(cur_nlast) + 64'd1);
        check_val("n_reqs", 64'(reqs), 64'(cur_nlast) + 64'd1);
        done_seen = 1'b1;
      end
    end
  end

  task automatic check_reset_outs(input string p);
    check_val({p, "_busy"},  64'(busy_o), 64'd0);
    check_val({p, "_done"},  64'(done_o), 64'd0);
    check_val({p, "_ena"},   64'(coe_rd_ena_o), 64'd0);
    check_val({p, "_addr"},  64'(coe_rd_addr_o), 64'd0);
    check_val({p, "_sel"},   64'(coe_rd_sel_o), 64'd0);
    check_val({p, "_valid"}, 64'(cg_valid_o), 64'd0);
    check_val({p, "_dat"},   64'(cg_dat_o != '0), 64'd0);
    check_val({p, "_idx"},   64'(cg_idx_o), 64'd0);
    check_val({p, "_nz"},    64'(cg_nz_o), 64'd0);
    check_val({p, "_cbf"},   64'(tu_cbf_o), 64'd0);
    check_val({p, "_last"},  64'(last_cg_o), 64'd0);
  endtask

  task automatic begin_tu(input logic [3:0] x, input logic [3:0] y, input logic [1:0] sz,
                          input logic [1:0] sel, input logic [8:0] base, input logic [63:0] zm,
                          input logic cbf, input logic [5:0] last, input int rmode);
    cur_base  = base;
    cur_sel   = sel;
    cur_nlast = (sz == 2'd0) ? 6'd0 : (sz == 2'd1) ? 6'd3 : (sz == 2'd2) ? 6'd15 : 6'd63;
    cur_zm    = zm;
    exp_cbf   = cbf;
    exp_last  = last;
    rdy_mode  = rmode;
    mon_en    = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b1; tu_x_i = x; tu_y_i = y; tu_size_i = sz; tu_sel_i = sel;
    @(posedge clk); #2;
    start_i = 1'b0;
    check_val("busy_c1", 64'(busy_o), 64'd1);
  endtask

  task automatic finish_tu(input bit chk_timing);
    for (int i = 0; i < 500; i++) begin
      if (done_seen) break;
      @(posedge clk);
    end
    if (!done_seen) begin
      check_val("done_timeout", 64'd0, 64'd1);
    end else begin
      if (chk_timing) begin
        check_val("first_req_cyc", 64'(first_req), 64'd1);
        check_val("first_val_cyc", 64'(first_val), 64'd3);
        check_val("done_cyc", 64'(done_rel), 64'(cur_nlast) + 64'd4);
      end
      @(posedge clk); #3;
      check_val("idle_busy", 64'(busy_o), 64'd0);
      check_val("hold_cbf", 64'(tu_cbf_o), 64'(exp_cbf));
      check_val("hold_last", 64'(last_cg_o), 64'(exp_last));
    end
    mon_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0;
    tu_x_i = '0; tu_y_i = '0; tu_size_i = '0; tu_sel_i = '0;
    repeat (3) @(posedge clk);
    #3;
    check_reset_outs("por");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // 4x4 Y at (3,5): single CG at 0x27
    begin_tu(4'd3, 4'd5, 2'd0, 2'd2, 9'h027, 64'h1, 1'b1, 6'd0, 0);
    finish_tu(1'b1);

    // 8x8 U at (2,2): 0x0C..0x0F; a second start mid-run must be ignored
    begin_tu(4'd2, 4'd2, 2'd1, 2'd1, 9'h00C, '1, 1'b1, 6'd3, 0);
    @(posedge clk); #2;
    start_i = 1'b1; tu_x_i = 4'd9; tu_size_i = 2'd0; tu_sel_i = 2'd0;
    @(posedge clk); #2;
    start_i = 1'b0;
    finish_tu(1'b1);

    // 32x32 Y at (0,0) with ready toggling
    begin_tu(4'd0, 4'd0, 2'd3, 2'd2, 9'h000, '1, 1'b1, 6'd63, 1);
    finish_tu(1'b0);

    // 16x16 at (4,8): only CG 9 nonzero
    begin_tu(4'd4, 4'd8, 2'd2, 2'd2, 9'h090, 64'h200, 1'b1, NZ ? 6'd9 : 6'd15, 0);
    finish_tu(1'b1);

    // 16x16 at unaligned (5,9) truncates to 0x90; all-zero coefficients
    begin_tu(4'd5, 4'd9, 2'd2, 2'd1, 9'h090, 64'h0, NZ ? 1'b0 : 1'b1, NZ ? 6'd0 : 6'd15, 0);
    finish_tu(1'b1);

    // 16x16 at (12,4) with ready held low for 10 cycles after first valid
    begin_tu(4'd12, 4'd4, 2'd2, 2'd0, 9'h070, '1, 1'b1, 6'd15, 2);
    finish_tu(1'b0);

    // reset in cycle 5 of a 16x16 TU
    begin_tu(4'd0, 4'd0, 2'd2, 2'd2, 9'h000, '1, 1'b1, 6'd15, 0);
    while ((cyc - t0) < 5) begin
      @(posedge clk); #2;
    end
    rst_n  = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #3;
    check_reset_outs("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // normal operation after the mid-run reset: 4x4 V at (1,0)
    begin_tu(4'd1, 4'd0, 2'd0, 2'd0, 9'h001, 64'h1, 1'b1, 6'd0, 0);
    finish_tu(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cabac_coe_fetch.md
# cabac_coe_fetch

Sequencer that walks every 4x4 coefficient group (CG) of one transform unit, issues read requests to the CABAC-side coefficient address transposer, captures the 16-coefficient words it returns one cycle later, and delivers them in Z-order to the residual coding engine over a valid/ready handshake. It sits between the CABAC control FSM (TU start) and the residual coder. A 2-entry buffer with credit accounting absorbs the fixed read latency under backpressure.

## Interface
- CW, `COEFF_WIDTH: width of one coefficient.
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start_i  in  1  TU start pulse; sampled only in IDLE.
- tu_x_i  in  4  TU x position in 4x4 units within the LCU.
- tu_y_i  in  4  TU y position in 4x4 units within the LCU.
- tu_size_i  in  2  0:4x4, 1:8x8, 2:16x16, 3:32x32.
- tu_sel_i  in  2  plane: 2=Y, 1=U, 0=V.
- busy_o  out  1  high from the cycle after accepted start until done_o.
- done_o  out  1  one-cycle pulse after the last CG handshake.
- coe_rd_ena_o  out  1  read request, active high.
- coe_rd_addr_o  out  9  Z-order 4x4 index; addr[2k]=x[k], addr[2k+1]=y[k], addr[8]=0.
- coe_rd_sel_o  out  2  latched tu_sel_i.
- coe_rd_dat_i  in  16*CW  CG data, valid exactly one cycle after the request.
- cg_valid_o  out  1  CG word available.
- cg_ready_i  in  1  consumer accepts.
- cg_dat_o  out  16*CW  CG coefficients, bit order as received.
- cg_idx_o  out  6  Z-order CG index within the TU.
- cg_nz_o  out  1  any coefficient in cg_dat_o nonzero.
- tu_cbf_o  out  1  OR of all cg_nz of the TU; valid with done_o.
- last_cg_o  out  6  highest cg_idx with cg_nz=1; valid with done_o.

## Operation
- FSM: IDLE -> RUN on start_i; RUN -> DRAIN when the last request is issued; DRAIN -> DONE when the buffer is empty and nothing is in flight; DONE -> IDLE after one cycle (done_o=1).
- On start, latch base = Morton(tu_x,tu_y), sel, N = 1/4/16/64 CGs; issue counter cnt = 0. Base low 2*tu_size bits are forced to 0 (unaligned TU positions are truncated).
- Request address = base | cnt; cnt increments per issued request.
- Issue condition in RUN: (count + inflight − pop) < 2, where pop = cg_valid_o & cg_ready_i, inflight = request issued last cycle.
- Returned data pushes into the 2-entry FIFO together with its cg_idx; nz computed on push (OR-reduce of all 16 coefficients ≠ 0).
- tu_cbf/last_cg accumulators clear on start, update on each pop.
- start_i while not IDLE: ignored.
- Outputs after reset: all 0 (busy_o, done_o, coe_rd_ena_o, coe_rd_addr_o, coe_rd_sel_o, cg_valid_o, cg_dat_o, cg_idx_o, cg_nz_o, tu_cbf_o, last_cg_o); FSM IDLE.

## Timing
- start accepted at cycle 0; first request cycle 1; first cg_valid_o cycle 3 (registered FIFO output).
- cg_ready_i held high: one CG per cycle; N CGs valid cycles 3..N+2, done_o at N+3.
- cg_dat_o/cg_idx_o/cg_nz_o stable while cg_valid_o=1 and cg_ready_i=0.
- Buffer never overflows: data returning for an in-flight request always has a slot.
- rst_n low mid-operation: FSM to IDLE, FIFO and in-flight request discarded, outputs to reset values next edge.
- tu_cbf_o/last_cg_o hold until the next accepted start.

## Configuration
- COE_FETCH_NZ_EN defined: cg_nz_o, tu_cbf_o, last_cg_o computed as above.
- Not defined: no OR-reduce logic; cg_nz_o tied 1, tu_cbf_o = 1 at done_o, last_cg_o = N−1.

## Test plan
- 4x4 Y TU at (3,5), ready=1, data nonzero -> single request addr 0x27 sel 2 at cycle 1; cg_valid_o cycle 3 idx 0 nz=1; done_o cycle 4; tu_cbf_o=1, last_cg_o=0.
- 8x8 U TU at (2,2), ready=1 -> addresses 0x0C..0x0F cycles 1-4, sel 1, idx 0..3 cycles 3-6, done_o cycle 7.
- 32x32 Y TU at (0,0), ready toggling 1/0 -> 64 CGs idx 0..63 in order, none lost or duplicated, requests never exceed buffer capacity.
- 16x16 TU with only CG 9 nonzero -> cg_nz_o=1 only for idx 9; tu_cbf_o=1, last_cg_o=9; all-zero TU -> tu_cbf_o=0, last_cg_o=0.
- ready held 0 for 10 cycles after first valid -> at most 2 requests issued, cg_dat_o stable; resume -> remaining CGs delivered.
- rst_n low at cycle 5 of a 16x16 TU -> next cycle all outputs 0, IDLE; new start works normally.
